tcm_dec_hd_align_buf: RTL and testbench

- Downstream neighbour of the 4D-8PSK hard-decision unit.
- Buffers each per-4D-symbol hard decision (4 x 2-bit subset-point indices) in a circular buffer.
- Releases the decisions in order when the Viterbi traceback emits the decoded coded bits for the same 4D symbol.
- Outputs the aligned {decoded bits, hard decision} pair to the uncoded-bit mapper.

---
 rtl/tcm_dec_hd_align_buf_if.sv | 66 ++++++
 rtl/tcm_dec_hd_align_buf.sv | 167 ++++++++++++++++
 tb/tb_tcm_dec_hd_align_buf.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcm_dec_hd_align_buf_if.sv
// Handshake/data bundle between the 4D-8PSK hard-decision unit, the Viterbi
// traceback and the alignment buffer.
// Optional macro TCM_DEC_HD_ALIGN_BUF_ERR_CNT_EN adds the oerr_cnt signal.
interface tcm_dec_hd_align_buf_if #(
   parameter int unsigned pADDR_W = 6,
   parameter int unsigned pHD_W   = 8,
   parameter int unsigned pDEC_W  = 7
);
   // upstream hard decision / traceback inputs
   logic                ival;
   logic [pHD_W-1:0]    ihd;
   logic                idec_val;
   logic [pDEC_W-1:0]   idec;

   // aligned output and status
   logic                oval;
   logic [pHD_W-1:0]    ohd;
   logic [pDEC_W-1:0]   odec;
   logic [pADDR_W:0]    ousedw;
   logic                ofull;
   logic                oempty;
   logic                oovf;
   logic                oudf;
`ifdef TCM_DEC_HD_ALIGN_BUF_ERR_CNT_EN
   logic [31:0]         oerr_cnt;
`endif

   // producer / consumer side (HD unit, traceback, uncoded-bit mapper)
   modport master (
      output ival,
      output ihd,
      output idec_val,
      output idec,
      input  oval,
      input  ohd,
      input  odec,
      input  ousedw,
      input  ofull,
      input  oempty,
      input  oovf,
      input  oudf
`ifdef TCM_DEC_HD_ALIGN_BUF_ERR_CNT_EN
      , input oerr_cnt
`endif
   );

   // alignment buffer side
   modport slave (
      input  ival,
      input  ihd,
      input  idec_val,
      input  idec,
      output oval,
      output ohd,
      output odec,
      output ousedw,
      output ofull,
      output oempty,
      output oovf,
      output oudf
`ifdef TCM_DEC_HD_ALIGN_BUF_ERR_CNT_EN
      , output oerr_cnt
`endif
   );

endinterface

// File: rtl/tcm_dec_hd_align_buf.sv
// Hard-decision alignment buffer: stores each per-4D-symbol hard decision in
// a circular buffer and releases it, in order, when the traceback emits the
// decoded coded bits of the same 4D symbol.
// Optional macro TCM_DEC_HD_ALIGN_BUF_ERR_CNT_EN adds saturating
// overflow/underflow event counters on bus.oerr_cnt.
module tcm_dec_hd_align_buf #(
   parameter int unsigned pADDR_W = 6,
   parameter int unsigned pHD_W   = 8,
   parameter int unsigned pDEC_W  = 7
) (
   input  logic                         iclk,
   input  logic                         ireset,
   input  logic                         iclkena,
   input  logic                         iclear,
   tcm_dec_hd_align_buf_if.slave        bus
);

   localparam int unsigned      cDEPTH = 1 << pADDR_W;
   localparam logic [pADDR_W:0] cFULL  = {1'b1, {pADDR_W{1'b0}}};
   localparam logic [pADDR_W:0] cONE   = {{pADDR_W{1'b0}}, 1'b1};

   logic [pHD_W-1:0]   mem [cDEPTH];

   logic [pADDR_W:0]   wr_ptr;
   logic [pADDR_W:0]   rd_ptr;
   logic [pADDR_W:0]   usedw;
   logic [pADDR_W:0]   usedw_nxt;
   logic               full;
   logic               empty;
   logic               oval;
   logic [pHD_W-1:0]   ohd;
   logic [pDEC_W-1:0]  odec;
   logic               ovf;
   logic               udf;

   logic               rd_acc;
   logic               wr_acc;
   logic               ovf_evt;
   logic               udf_evt;

   // accept/reject decisions from the registered full/empty flags; a read in
   // the same cycle frees the slot a write into a full buffer needs
   always_comb begin
      rd_acc    = bus.idec_val & ~empty;
      wr_acc    = bus.ival & (~full | rd_acc);
      ovf_evt   = bus.ival & full & ~rd_acc;
      udf_evt   = bus.idec_val & empty;
      usedw_nxt = usedw;
      if (wr_acc && !rd_acc) begin
         usedw_nxt = usedw + cONE;
      end else if (rd_acc && !wr_acc) begin
         usedw_nxt = usedw - cONE;
      end
   end

   // buffer storage write port (no reset so it maps onto block RAM)
   always_ff @(posedge iclk) begin
      if (iclkena && !iclear && wr_acc) begin
         mem[wr_ptr[pADDR_W-1:0]] <= bus.ihd;
      end
   end

   // pointers, occupancy and registered full/empty flags
   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         usedw  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else if (iclkena) begin
         if (iclear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            usedw  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
         end else begin
            if (wr_acc) begin
               wr_ptr <= wr_ptr + cONE;
            end
            if (rd_acc) begin
               rd_ptr <= rd_ptr + cONE;
            end
            usedw <= usedw_nxt;
            full  <= (usedw_nxt == cFULL);
            empty <= (usedw_nxt == '0);
         end
      end
   end

   // registered RAM read and aligned output word; data holds when idle
   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         oval <= 1'b0;
         ohd  <= '0;
         odec <= '0;
      end else if (iclkena) begin
         if (iclear) begin
            oval <= 1'b0;
         end else if (rd_acc) begin
            oval <= 1'b1;
            ohd  <= mem[rd_ptr[pADDR_W-1:0]];
            odec <= bus.idec;
         end else begin
            oval <= 1'b0;
         end
      end
   end

   // sticky overflow/underflow flags, cleared only by reset or frame start
   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         ovf <= 1'b0;
         udf <= 1'b0;
      end else if (iclkena) begin
         if (iclear) begin
            ovf <= 1'b0;
            udf <= 1'b0;
         end else begin
            if (ovf_evt) begin
               ovf <= 1'b1;
            end
            if (udf_evt) begin
               udf <= 1'b1;
            end
         end
      end
   end

   assign bus.oval   = oval;
   assign bus.ohd    = ohd;
   assign bus.odec   = odec;
   assign bus.ousedw = usedw;
   assign bus.ofull  = full;
   assign bus.oempty = empty;
   assign bus.oovf   = ovf;
   assign bus.oudf   = udf;

`ifdef TCM_DEC_HD_ALIGN_BUF_ERR_CNT_EN
   logic [15:0] ovf_cnt;
   logic [15:0] udf_cnt;

   // saturating event counters, stepping on the same events as the flags
   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         ovf_cnt <= '0;
         udf_cnt <= '0;
      end else if (iclkena) begin
         if (iclear) begin
            ovf_cnt <= '0;
            udf_cnt <= '0;
         end else begin
            if (ovf_evt && (ovf_cnt != '1)) begin
               ovf_cnt <= ovf_cnt + 16'd1;
            end
            if (udf_evt && (udf_cnt != '1)) begin
               udf_cnt <= udf_cnt + 16'd1;
            end
         end
      end
   end

   assign bus.oerr_cnt = {udf_cnt, ovf_cnt};
`endif

endmodule

// File: tb/tb_tcm_dec_hd_align_buf.sv
// Self-checking bench for tcm_dec_hd_align_buf against a queue-based model.
// Honours TCM_DEC_HD_ALIGN_BUF_ERR_CNT_EN when the design is built with it.
module tb_tcm_dec_hd_align_buf;

   localparam int unsigned AW    = 6;
   localparam int unsigned HW    = 8;
   localparam int unsigned DW    = 7;
   localparam int unsigned DEPTH = 64;

   logic iclk    = 1'b0;
   logic ireset  = 1'b0;
   logic iclkena = 1'b0;
   logic iclear  = 1'b0;

   tcm_dec_hd_align_buf_if #(.pADDR_W(AW), .pHD_W(HW), .pDEC_W(DW)) bus ();

   tcm_dec_hd_align_buf #(.pADDR_W(AW), .pHD_W(HW), .pDEC_W(DW)) dut (
      .iclk    (iclk),
      .ireset  (ireset),
      .iclkena (iclkena),
      .iclear  (iclear),
      .bus     (bus)
   );

   always #5 iclk = ~iclk;

   // reference model state
   logic [7:0]  q [$];
   logic        m_oval;
   logic [7:0]  m_ohd;
   logic [6:0]  m_odec;
   logic        m_ovf;
   logic        m_udf;
   logic [15:0] m_ovf_cnt;
   logic [15:0] m_udf_cnt;

   int total = 0;
   int bad   = 0;

   localparam logic [26:0] RESET_VEC = {1'b0, 8'h00, 7'h00, 7'h00, 1'b0, 1'b1, 1'b0, 1'b0};

   function automatic logic [26:0] obs();
      return {bus.oval, bus.ohd, bus.odec, bus.ousedw, bus.ofull, bus.oempty, bus.oovf, bus.oudf};
   endfunction

   function automatic logic [26:0] exp_v();
      logic [6:0] u;
      u = 7'(q.size());
      return {m_oval, m_ohd, m_odec, u, (q.size() == DEPTH), (q.size() == 0), m_ovf, m_udf};
   endfunction

   task automatic model_reset();
      q.delete();
      m_oval = 1'b0; m_ohd = '0; m_odec = '0;
      m_ovf = 1'b0; m_udf = 1'b0;
      m_ovf_cnt = '0; m_udf_cnt = '0;
   endtask

   // drive one clock of inputs, advance the model, step past the edge
   task automatic cycle(input logic en, input logic clr, input logic v,
                        input logic [7:0] hd, input logic dv, input logic [6:0] dec);
      logic was_full, was_empty, rd;
      bus.ival = v; bus.ihd = hd; bus.idec_val = dv; bus.idec = dec;
      iclkena = en; iclear = clr;
      if (en) begin
         if (clr) begin
            q.delete();
            m_oval = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
            m_ovf_cnt = '0; m_udf_cnt = '0;
         end else begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            rd = dv && !was_empty;
            if (rd) begin
               m_ohd = q.pop_front(); m_odec = dec; m_oval = 1'b1;
            end else begin
               m_oval = 1'b0;
            end
            if (dv && was_empty) begin
               m_udf = 1'b1;
               if (m_udf_cnt != 16'hFFFF) m_udf_cnt++;
            end
            if (v) begin
               if (!was_full || rd) q.push_back(hd);
               else begin
                  m_ovf = 1'b1;
                  if (m_ovf_cnt != 16'hFFFF) m_ovf_cnt++;
               end
            end
         end
      end
      @(posedge iclk);
      #1;
   endtask

   task automatic test_reset();
      bus.ival = 1'b0; bus.ihd = '0; bus.idec_val = 1'b0; bus.idec = '0;
      ireset = 1'b0;
      #12;
      total++;
      if (obs() !== RESET_VEC) begin
         bad++; $display("FAIL reset_state got %h want %h", obs(), RESET_VEC);
      end
      ireset = 1'b1;
      model_reset();
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 7'h00);
      total++;
      if (obs() !== exp_v()) begin
         bad++; $display("FAIL reset_idle got %h want %h", obs(), exp_v());
      end
   endtask

   task automatic test_basic();
      logic [7:0] hd [5];
      hd[0] = 8'h1B; hd[1] = 8'hE4; hd[2] = 8'h00; hd[3] = 8'hFF; hd[4] = 8'h5A;
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'b0, 1'b1, hd[i], 1'b0, 7'h00);
         total++;
         if (obs() !== exp_v()) begin
            bad++; $display("FAIL basic_wr%0d got %h want %h", i, obs(), exp_v());
         end
      end
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 7'(i));
         total++;
         if (bus.oval !== 1'b1 || bus.ohd !== hd[i] || bus.odec !== 7'(i)) begin
            bad++; $display("FAIL basic_rd%0d got val=%b hd=%h dec=%h want val=1 hd=%h dec=%h",
                            i, bus.oval, bus.ohd, bus.odec, hd[i], 7'(i));
         end
      end
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 7'h00);
      total++;
      if (bus.oval !== 1'b0 || bus.ousedw !== 7'd0 || bus.oempty !== 1'b1 || bus.ohd !== 8'h5A) begin
         bad++; $display("FAIL basic_drained got val=%b used=%0d empty=%b hd=%h want 0/0/1/5a",
                         bus.oval, bus.ousedw, bus.oempty, bus.ohd);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] words [65];
      cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 7'h00);
      for (int i = 0; i < 65; i++) begin
         words[i] = 8'($urandom);
         cycle(1'b1, 1'b0, 1'b1, words[i], 1'b0, 7'h00);
         total++;
         if (obs() !== exp_v()) begin
            bad++; $display("FAIL ovf_fill%0d got %h want %h", i, obs(), exp_v());
         end
      end
      total++;
      if (bus.ofull !== 1'b1 || bus.ousedw !== 7'd64 || bus.oovf !== 1'b1) begin
         bad++; $display("FAIL ovf_flags got full=%b used=%0d ovf=%b want 1/64/1",
                         bus.ofull, bus.ousedw, bus.oovf);
      end
      for (int i = 0; i < 64; i++) begin
         cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 7'($urandom));
         total++;
         if (bus.oval !== 1'b1 || bus.ohd !== words[i] || obs() !== exp_v()) begin
            bad++; $display("FAIL ovf_drain%0d got %h want hd=%h vec=%h", i, obs(), words[i], exp_v());
         end
      end
   endtask

   task automatic test_underflow_nobypass();
      cycle(1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 7'h03);
      total++;
      if (bus.oval !== 1'b0 || bus.oudf !== 1'b1 || bus.ousedw !== 7'd1 || obs() !== exp_v()) begin
         bad++; $display("FAIL udf_bypass got %h want val=0 udf=1 used=1 vec=%h", obs(), exp_v());
      end
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 7'h05);
      total++;
      if (bus.oval !== 1'b1 || bus.ohd !== 8'hA5 || bus.odec !== 7'h05) begin
         bad++; $display("FAIL udf_next got val=%b hd=%h dec=%h want 1/a5/05", bus.oval, bus.ohd, bus.odec);
      end
   endtask

   task automatic test_back_to_back();
      cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 7'h00);
      for (int i = 0; i < 64; i++) cycle(1'b1, 1'b0, 1'b1, 8'($urandom), 1'b0, 7'h00);
      for (int i = 0; i < 200; i++) begin
         cycle(1'b1, 1'b0, 1'b1, 8'($urandom), 1'b1, 7'($urandom));
         total++;
         if (bus.oovf !== 1'b0 || bus.oudf !== 1'b0 || bus.ousedw !== 7'd64 || obs() !== exp_v()) begin
            bad++; $display("FAIL b2b%0d got %h want %h", i, obs(), exp_v());
         end
      end
   endtask

   task automatic test_clear();
      cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 7'h00);
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 7'h00);
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b1, 8'($urandom), 1'b0, 7'h00);
      cycle(1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 7'h11);
      total++;
      if (bus.oudf !== 1'b1 || bus.oval !== 1'b1 || bus.ousedw !== 7'd10 || obs() !== exp_v()) begin
         bad++; $display("FAIL clr_pre got %h want %h", obs(), exp_v());
      end
      cycle(1'b1, 1'b1, 1'b1, 8'h77, 1'b1, 7'h22);
      total++;
      if (bus.ousedw !== 7'd0 || bus.oval !== 1'b0 || bus.oudf !== 1'b0 || bus.oovf !== 1'b0 ||
          bus.oempty !== 1'b1 || obs() !== exp_v()) begin
         bad++; $display("FAIL clr_state got %h want %h", obs(), exp_v());
      end
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 7'h33);
      total++;
      if (bus.oval !== 1'b0 || bus.oudf !== 1'b1 || obs() !== exp_v()) begin
         bad++; $display("FAIL clr_discard got %h want %h", obs(), exp_v());
      end
   endtask

   task automatic test_random_clkena();
      logic en, clr, v, dv;
      cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 7'h00);
      for (int i = 0; i < 600; i++) begin
         en  = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 99) == 0);
         v   = ($urandom_range(0, 99) < ((i / 150) % 2 == 0 ? 75 : 35));
         dv  = ($urandom_range(0, 99) < ((i / 150) % 2 == 0 ? 35 : 75));
         cycle(en, clr, v, 8'($urandom), dv, 7'($urandom));
         total++;
         if (obs() !== exp_v()) begin
            bad++; $display("FAIL rand%0d got %h want %h", i, obs(), exp_v());
         end
`ifdef TCM_DEC_HD_ALIGN_BUF_ERR_CNT_EN
         total++;
         if (bus.oerr_cnt !== {m_udf_cnt, m_ovf_cnt}) begin
            bad++; $display("FAIL rand_cnt%0d got %h want %h", i, bus.oerr_cnt, {m_udf_cnt, m_ovf_cnt});
         end
`endif
      end
   endtask

`ifdef TCM_DEC_HD_ALIGN_BUF_ERR_CNT_EN
   task automatic test_err_cnt();
      cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 7'h00);
      for (int i = 0; i < 67; i++) cycle(1'b1, 1'b0, 1'b1, 8'($urandom), 1'b0, 7'h00);
      for (int i = 0; i < 66; i++) cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 7'($urandom));
      total++;
      if (bus.oerr_cnt !== 32'h0002_0003) begin
         bad++; $display("FAIL err_cnt got %h want 00020003", bus.oerr_cnt);
      end
   endtask
`endif

   task automatic test_async_reset();
      cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 7'h00);
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 7'h00);
      for (int i = 0; i < 64; i++) cycle(1'b1, 1'b0, 1'b1, 8'($urandom), 1'b0, 7'h00);
      cycle(1'b1, 1'b0, 1'b1, 8'h99, 1'b0, 7'h00);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 7'($urandom));
      total++;
      if (bus.oval !== 1'b1 || bus.oovf !== 1'b1 || obs() !== exp_v()) begin
         bad++; $display("FAIL arst_pre got %h want %h", obs(), exp_v());
      end
      #2;
      ireset = 1'b0;
      #1;
      total++;
      if (obs() !== RESET_VEC) begin
         bad++; $display("FAIL arst_async got %h want %h", obs(), RESET_VEC);
      end
`ifdef TCM_DEC_HD_ALIGN_BUF_ERR_CNT_EN
      total++;
      if (bus.oerr_cnt !== 32'h0) begin
         bad++; $display("FAIL arst_cnt got %h want 00000000", bus.oerr_cnt);
      end
`endif
      @(posedge iclk);
      #1;
      total++;
      if (obs() !== RESET_VEC) begin
         bad++; $display("FAIL arst_hold got %h want %h", obs(), RESET_VEC);
      end
      ireset = 1'b1;
      model_reset();
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 7'h00);
      total++;
      if (obs() !== exp_v()) begin
         bad++; $display("FAIL arst_after got %h want %h", obs(), exp_v());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_underflow_nobypass();
      test_back_to_back();
      test_clear();
      test_random_clkena();
`ifdef TCM_DEC_HD_ALIGN_BUF_ERR_CNT_EN
      test_err_cnt();
`endif
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
